// File: rtl/ip_slave_chain_sequencer_if.sv
// Port bundle for ip_slave_chain_sequencer: step-table programming, chain
// control, slave start/interrupt lines and the master-facing status.
// The master modport drives the sequencer; the slave modport is the sequencer.
interface ip_slave_chain_sequencer_if #(
  parameter int NUM_SLAVES = 11,
  parameter int SEL_WIDTH  = 4,
  parameter int MAX_STEPS  = 8,
  parameter int STEP_AW    = 3,
  parameter int TO_WIDTH   = 16
);
  logic                  i_prog_we;
  logic [STEP_AW-1:0]    i_prog_addr;
  logic [SEL_WIDTH-1:0]  i_prog_sel;
  logic [STEP_AW-1:0]    i_last;
  logic [TO_WIDTH-1:0]   i_timeout;
  logic                  i_go;
  logic                  i_abort;
  logic                  i_int_ack;
  logic [NUM_SLAVES-1:0] i_int_slv;
  logic [NUM_SLAVES-1:0] o_start_slv;
  logic                  o_busy;
  logic [STEP_AW-1:0]    o_step;
  logic                  o_int_req;
  logic [1:0]            o_status;

  modport master (
    output i_prog_we, i_prog_addr, i_prog_sel, i_last, i_timeout,
    output i_go, i_abort, i_int_ack, i_int_slv,
    input  o_start_slv, o_busy, o_step, o_int_req, o_status
  );

  modport slave (
    input  i_prog_we, i_prog_addr, i_prog_sel, i_last, i_timeout,
    input  i_go, i_abort, i_int_ack, i_int_slv,
    output o_start_slv, o_busy, o_step, o_int_req, o_status
  );
endinterface

// File: rtl/ip_slave_chain_sequencer.sv
// ip_slave_chain_sequencer: walks a programmed table of slave indices,
// pulsing each slave's start line and waiting for that slave's interrupt
// rising edge before moving on; raises one interrupt to the master at the end.
// Optional feature macro: SEQ_TIMEOUT_EN adds a per-step watchdog that ends
// the chain with status 10 when a slave stays silent too long.
module ip_slave_chain_sequencer #(
  parameter int NUM_SLAVES = 11,
  parameter int SEL_WIDTH  = 4,
  parameter int MAX_STEPS  = 8,
  parameter int STEP_AW    = 3,
  parameter int TO_WIDTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  ip_slave_chain_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_DONE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_END} state_t;

  state_t                state_reg, state_next;
  logic [STEP_AW-1:0]    step_reg, step_next;
  logic [STEP_AW-1:0]    last_reg, last_next;
  logic [1:0]            status_reg, status_next;
  logic [NUM_SLAVES-1:0] int_prev_reg;

  // Small table read combinationally: the step index moves in the same
  // cycle the next LAUNCH needs its entry, and a write in IDLE must be
  // visible to a go issued right after it.
  logic [SEL_WIDTH-1:0]  step_tbl [MAX_STEPS];
  logic [SEL_WIDTH-1:0]  cur_sel;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic [NUM_SLAVES-1:0] int_rise;
  logic                  sel_valid;
  logic                  sel_edge;
  logic                  tbl_we;
  logic                  launch_fire;
  logic                  timeout_hit;

  assign cur_sel = step_tbl[step_reg];

  // Decode the current slave index and find fresh rising edges per line.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
      assign sel_onehot[gi] = (cur_sel == SEL_WIDTH'(gi));
      assign int_rise[gi]   = bus.i_int_slv[gi] & ~int_prev_reg[gi];
    end
  endgenerate

  // Indices beyond the last slave decode to all-zero, which flags them invalid.
  assign sel_valid = |sel_onehot;
  assign sel_edge  = |(int_rise & sel_onehot);

  assign tbl_we = bus.i_prog_we && (state_reg == S_IDLE || state_reg == S_END);

  // Step table storage; cleared on reset, frozen while a chain runs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_STEPS; i++) step_tbl[i] <= '0;
    end else if (tbl_we) begin
      step_tbl[bus.i_prog_addr] <= bus.i_prog_sel;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [TO_WIDTH-1:0] limit_reg, limit_next;
  logic [TO_WIDTH-1:0] timer_reg, timer_next;

  // Watchdog: limit latched on go, reloaded per LAUNCH, counted down in WAIT.
  always_comb begin
    limit_next  = limit_reg;
    timer_next  = timer_reg;
    timeout_hit = 1'b0;
    if (state_reg == S_IDLE && bus.i_go) begin
      limit_next = bus.i_timeout;
    end
    if (state_reg == S_LAUNCH) begin
      timer_next = limit_reg;
    end else if (state_reg == S_WAIT && limit_reg != '0) begin
      timer_next  = timer_reg - TO_WIDTH'(1);
      timeout_hit = (timer_reg == TO_WIDTH'(1));
    end
  end

  // Watchdog registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      limit_reg <= '0;
      timer_reg <= '0;
    end else begin
      limit_reg <= limit_next;
      timer_reg <= timer_next;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^bus.i_timeout;
  assign timeout_hit    = 1'b0;
`endif

  // Next-state logic; abort outranks an edge, an edge outranks a timeout.
  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    last_next   = last_reg;
    status_next = status_reg;
    launch_fire = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.i_go) begin
          state_next  = S_LAUNCH;
          step_next   = '0;
          last_next   = bus.i_last;
          status_next = ST_NONE;
        end
      end
      S_LAUNCH: begin
        if (bus.i_abort || !sel_valid) begin
          state_next  = S_END;
          status_next = ST_ABORT;
        end else begin
          launch_fire = 1'b1;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_abort) begin
          state_next  = S_END;
          status_next = ST_ABORT;
        end else if (sel_edge) begin
          if (step_reg == last_reg) begin
            state_next  = S_END;
            status_next = ST_DONE;
          end else begin
            step_next  = step_reg + STEP_AW'(1);
            state_next = S_LAUNCH;
          end
        end else if (timeout_hit) begin
          state_next  = S_END;
          status_next = ST_TIMEOUT;
        end
      end
      S_END: begin
        if (bus.i_int_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control registers plus interrupt-line history for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= S_IDLE;
      step_reg     <= '0;
      last_reg     <= '0;
      status_reg   <= ST_NONE;
      int_prev_reg <= '0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      last_reg     <= last_next;
      status_reg   <= status_next;
      int_prev_reg <= bus.i_int_slv;
    end
  end

  assign bus.o_start_slv = launch_fire ? sel_onehot : '0;
  assign bus.o_busy      = (state_reg == S_LAUNCH) || (state_reg == S_WAIT);
  assign bus.o_step      = step_reg;
  assign bus.o_int_req   = (state_reg == S_END);
  assign bus.o_status    = status_reg;

endmodule

// File: doc/ip_slave_chain_sequencer.md
# ip_slave_chain_sequencer

Hardware sequencer that runs a programmed chain of AIP slave operations on the master SoC controller's slave ports without MCU intervention per step. It holds a step table of slave indices. For each step it pulses that slave's start line, then waits for that slave's interrupt before launching the next step. At the end of the chain it raises a single interrupt toward the master, which reduces MCU traffic from one start/interrupt pair per slave to one per chain.

## Interface
- NUM_SLAVES, 11, number of slave start/interrupt lines
- SEL_WIDTH, 4, width of a slave index
- MAX_STEPS, 8, step table depth (power of two)
- STEP_AW, 3, log2(MAX_STEPS)
- TO_WIDTH, 16, timeout counter width

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_prog_we  in  1  write step table entry
- i_prog_addr  in  STEP_AW  step table address
- i_prog_sel  in  SEL_WIDTH  slave index to store
- i_last  in  STEP_AW  index of final step; sampled on accepted go
- i_timeout  in  TO_WIDTH  per-step cycle limit; 0 = no limit; sampled on accepted go
- i_go  in  1  start chain (pulse)
- i_abort  in  1  abandon running chain
- i_int_ack  in  1  clear o_int_req
- i_int_slv  in  NUM_SLAVES  slave interrupt lines (level)
- o_start_slv  out  NUM_SLAVES  one-hot, one-cycle start pulse
- o_busy  out  1  chain in progress (LAUNCH or WAIT)
- o_step  out  STEP_AW  current step index
- o_int_req  out  1  chain finished, level until acked
- o_status  out  2  00 none, 01 done, 10 timeout, 11 aborted/invalid slave

## Operation
- States: IDLE, LAUNCH, WAIT, END.
- Reset: state IDLE, table all zero, o_start_slv 0, o_busy 0, o_step 0, o_int_req 0, o_status 00, int history 0.
- Table writes are accepted only in IDLE or END; ignored in LAUNCH/WAIT.
- IDLE: i_go → LAUNCH, step=0, latch i_last and i_timeout.
- LAUNCH, one cycle only:
  - If table[step] ≥ NUM_SLAVES: no pulse, go to END with status 11.
  - Otherwise: o_start_slv = one-hot(table[step]), load timer, go to WAIT.
- WAIT: detect a rising edge on i_int_slv[table[step]] (current high, registered previous low). Levels already high are never counted.
  - Edge and step==last → END with status 01.
  - Edge and step<last → step+1, go to LAUNCH.
- END: o_int_req=1. i_int_ack → IDLE, o_int_req=0. o_status holds until the next accepted go, which clears it to 00.
- i_abort in LAUNCH/WAIT → END with status 11. Abort has priority over a same-cycle edge. Abort is ignored in IDLE/END.
- i_go is ignored outside IDLE. In END, go is ignored even in the same cycle as ack.
- Edges on interrupt lines of non-selected slaves are ignored.

## Timing
- Go sampled at edge k: state LAUNCH and o_start_slv pulse in cycle k+1. o_busy goes high in cycle k+1.
- Interrupt edge sampled at edge c in WAIT: next step's start pulse in cycle c+1.
- Final interrupt edge at c: o_int_req=1, o_status=01, o_busy=0 from cycle c+1.
- Minimum per-step period is 2 cycles (LAUNCH + one WAIT cycle).
- Ack at edge a: o_int_req=0 from cycle a+1. Go is accepted from edge a+1.
- Reset asserted mid-chain: all outputs return to reset values the cycle after. No start pulse is emitted in that cycle.

## Configuration
- SEQ_TIMEOUT_EN defined, with a latched i_timeout=T≠0:
  - The timer is loaded with T in LAUNCH and decrements each WAIT cycle.
  - If it reaches 0 with no edge → END with status 10, o_step = failing step.
  - An edge in the same cycle the timer hits 0 wins.
- SEQ_TIMEOUT_EN undefined: no timer logic; i_timeout is ignored; WAIT lasts until an edge or abort. Status 10 is never produced.

## Test plan
- Program table {3,7,0}, i_last=2, go: start pulses on bits 3, 7, 0 in that order, each one cycle after the previous slave's interrupt rises. End state: o_int_req=1, o_status=01, o_step=2.
- Slave 3 interrupt held high before go: no advance. A low-then-high edge advances one cycle later.
- Table entry 12 at step 1: step 0 runs; then no pulse, o_status=11, o_int_req=1, o_step=1.
- With SEQ_TIMEOUT_EN and i_timeout=5, slave silent: o_status=10 within 6 cycles of the start pulse. Without the macro, still busy after 1000 cycles.
- Abort in the same cycle as the awaited interrupt edge: o_status=11 and no further start pulse. Go during busy and table writes during busy have no effect.
- Reset during WAIT at step 1: next cycle all outputs zero. A new go restarts from step 0.
